// File: rtl/radar_target_emulator_pkg.sv
// Shared radar definitions: physical constants, the emulator FSM encoding
// and a saturating clamp for range arithmetic in metres.
package radar_pkg;

  localparam int unsigned SPEED_OF_LIGHT_MPS = 300000000;
  localparam int unsigned US_PER_S           = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ECHO  = 2'd2
  } emu_state_t;

  // Clamp a signed 34-bit range value into [0, hi].
  function automatic logic [31:0] clamp_m(input logic signed [33:0] v,
                                          input logic [31:0]        hi);
    logic signed [33:0] hi_s;
    hi_s = $signed({2'b00, hi});
    if (v[33])
      return '0;
    else if (v > hi_s)
      return hi;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/radar_target_emulator_target_motion.sv
// Target range model: periodic motion by a signed closing rate, with an
// immediate load strobe that also restarts the motion tick.
module target_motion
  import radar_pkg::*;
#(
  parameter int unsigned MOTION_TICK_CYCLES = 1000,
  parameter logic [31:0] MAX_DISTANCE       = 32'd300000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_distance,
  input  logic [31:0]        initial_distance,
  input  logic signed [31:0] closing_rate,
  output logic [31:0]        target_distance
);

  localparam logic [31:0] TICK_LAST = 32'(MOTION_TICK_CYCLES - 1);

  logic [31:0]        tick_cnt;
  logic signed [33:0] moved;
  logic [31:0]        load_val;

  // Candidate range after one motion step, and the ceiling-limited load value.
  always_comb begin
    moved    = $signed({2'b00, target_distance}) -
               $signed({{2{closing_rate[31]}}, closing_rate});
    load_val = (initial_distance > MAX_DISTANCE) ? MAX_DISTANCE : initial_distance;
  end

  // Tick counter and range register; a load takes priority over a tick wrap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_cnt        <= '0;
      target_distance <= '0;
    end else if (load_distance) begin
      tick_cnt        <= '0;
      target_distance <= load_val;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt        <= '0;
      target_distance <= clamp_m(moved, MAX_DISTANCE);
    end else begin
      tick_cnt        <= tick_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/radar_target_emulator.sv
// Synthetic radar target: measures delay from the trigger falling edge and
// answers with a fixed-width echo after the round-trip time for the current range.
module radar_target_emulator
  import radar_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_US      = 1,
  parameter int unsigned M_PER_CYCLE        = (SPEED_OF_LIGHT_MPS / US_PER_S / 2) * CLK_PERIOD_US,
  parameter int unsigned ECHO_WIDTH         = 4,
  parameter int unsigned MOTION_TICK_CYCLES = 1000,
  parameter logic [31:0] MAX_DISTANCE       = 32'd300000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               radar_pulse_trigger,
  input  logic               target_enable,
  input  logic               load_distance,
  input  logic [31:0]        initial_distance,
  input  logic signed [31:0] closing_rate,
  output logic               radar_echo,
  output logic [31:0]        target_distance,
  output logic [15:0]        echo_count,
  output logic               pulse_overrun,
  output logic               busy
);

  localparam logic [32:0] M_STEP     = 33'(M_PER_CYCLE);
  localparam logic [31:0] WIDTH_LAST = 32'(ECHO_WIDTH - 1);

  emu_state_t  state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic        echo_d, overrun_d, busy_d;
  logic [15:0] count_d;
  logic        trig_q;
  logic        fall;

  target_motion #(
    .MOTION_TICK_CYCLES(MOTION_TICK_CYCLES),
    .MAX_DISTANCE      (MAX_DISTANCE)
  ) u_motion (
    .CLK             (CLK),
    .RST             (RST),
    .load_distance   (load_distance),
    .initial_distance(initial_distance),
    .closing_rate    (closing_rate),
    .target_distance (target_distance)
  );

  assign fall = trig_q & ~radar_pulse_trigger;

  // Next-state and output decode; acc is loaded at the fall edge so the echo
  // rises max(1, ceil(range/M_PER_CYCLE)) edges later.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    snap_d    = snap_q;
    wcnt_d    = wcnt_q;
    echo_d    = radar_echo;
    count_d   = echo_count;
    overrun_d = pulse_overrun;
    unique case (state_q)
      ST_IDLE: begin
        if (fall && target_enable && (target_distance <= MAX_DISTANCE)) begin
          snap_d  = target_distance;
          acc_d   = M_STEP;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (fall) overrun_d = 1'b1;
        if (!target_enable) begin
          state_d = ST_IDLE;
        end else if (acc_q >= {1'b0, snap_q}) begin
          state_d = ST_ECHO;
          echo_d  = 1'b1;
          wcnt_d  = '0;
          count_d = echo_count + 16'd1;
        end else begin
          acc_d = acc_q + M_STEP;
        end
      end
      ST_ECHO: begin
        if (fall) overrun_d = 1'b1;
        if (wcnt_q == WIDTH_LAST) begin
          state_d = ST_IDLE;
          echo_d  = 1'b0;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        echo_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, timing and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      snap_q        <= '0;
      wcnt_q        <= '0;
      trig_q        <= 1'b0;
      radar_echo    <= 1'b0;
      echo_count    <= '0;
      pulse_overrun <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      snap_q        <= snap_d;
      wcnt_q        <= wcnt_d;
      trig_q        <= radar_pulse_trigger;
      radar_echo    <= echo_d;
      echo_count    <= count_d;
      pulse_overrun <= overrun_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_radar_target_emulator.sv
// Directed bench for radar_target_emulator: range table plus hand sequences
// for overrun, disable, motion saturation, snapshot and async reset.
module tb_radar_target_emulator;

  localparam int ECHO_W = 4;

  logic               CLK = 1'b0;
  logic               RST;
  logic               radar_pulse_trigger;
  logic               target_enable;
  logic               load_distance;
  logic [31:0]        initial_distance;
  logic signed [31:0] closing_rate;

  logic               radar_echo;
  logic [31:0]        target_distance;
  logic [15:0]        echo_count;
  logic               pulse_overrun;
  logic               busy;

  logic               c_echo;
  logic [31:0]        c_distance;
  logic [15:0]        c_count;
  logic               c_overrun;
  logic               c_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_count = '0;

  typedef struct {
    logic [31:0] load;
    logic [31:0] exp_dist;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  always #5 CLK = ~CLK;

  radar_target_emulator #(
    .ECHO_WIDTH  (ECHO_W),
    .MAX_DISTANCE(32'd300000)
  ) u_dut (
    .CLK                (CLK),
    .RST                (RST),
    .radar_pulse_trigger(radar_pulse_trigger),
    .target_enable      (target_enable),
    .load_distance      (load_distance),
    .initial_distance   (initial_distance),
    .closing_rate       (closing_rate),
    .radar_echo         (radar_echo),
    .target_distance    (target_distance),
    .echo_count         (echo_count),
    .pulse_overrun      (pulse_overrun),
    .busy               (busy)
  );

  radar_target_emulator #(
    .ECHO_WIDTH  (ECHO_W),
    .MAX_DISTANCE(32'd100000)
  ) u_clamp (
    .CLK                (CLK),
    .RST                (RST),
    .radar_pulse_trigger(radar_pulse_trigger),
    .target_enable      (target_enable),
    .load_distance      (load_distance),
    .initial_distance   (initial_distance),
    .closing_rate       (closing_rate),
    .radar_echo         (c_echo),
    .target_distance    (c_distance),
    .echo_count         (c_count),
    .pulse_overrun      (c_overrun),
    .busy               (c_busy)
  );

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [31:0] v);
    initial_distance = v;
    load_distance    = 1'b1;
    tick();
    load_distance    = 1'b0;
  endtask

  task automatic arm();
    radar_pulse_trigger = 1'b1;
    tick();
    tick();
  endtask

  // Drops the trigger (fall at edge k = j 0) and watches the echo window.
  // fall2_at > 0: second fall at edge k+fall2_at; dis_at > 0: enable low from k+dis_at+1.
  task automatic run_echo(input int exp_n, input int fall2_at, input int dis_at,
                          input string nm);
    int   rise;
    int   width;
    int   limit;
    logic busy_ok;
    logic exp_busy;
    rise    = -1;
    width   = 0;
    busy_ok = 1'b1;
    limit   = ((exp_n > 0) ? exp_n : 20) + ECHO_W + 4;
    radar_pulse_trigger = 1'b0;
    tick();
    for (int j = 0; j <= limit; j++) begin
      if (j > 0) begin
        radar_pulse_trigger = (fall2_at > 0) && (j < fall2_at);
        if ((dis_at > 0) && (j > dis_at)) target_enable = 1'b0;
        tick();
      end
      if (radar_echo === 1'b1) begin
        if (rise < 0) rise = j;
        width++;
      end
      if (exp_n > 0)       exp_busy = (j < exp_n + ECHO_W);
      else if (dis_at > 0) exp_busy = (j <= dis_at);
      else                 exp_busy = 1'b0;
      if (busy !== exp_busy) busy_ok = 1'b0;
    end
    radar_pulse_trigger = 1'b0;
    target_enable       = 1'b1;
    chk({nm, "_rise"}, rise, (exp_n > 0) ? exp_n : -1);
    chk({nm, "_width"}, width, (exp_n > 0) ? ECHO_W : 0);
    chk({nm, "_busy"}, busy_ok, 1);
  endtask

  initial begin
    vecs[0] = '{load: 32'd3000,   exp_dist: 32'd3000,   exp_n: 20};
    vecs[1] = '{load: 32'd0,      exp_dist: 32'd0,      exp_n: 1};
    vecs[2] = '{load: 32'd150,    exp_dist: 32'd150,    exp_n: 1};
    vecs[3] = '{load: 32'd151,    exp_dist: 32'd151,    exp_n: 2};
    vecs[4] = '{load: 32'd4500,   exp_dist: 32'd4500,   exp_n: 30};
    vecs[5] = '{load: 32'd400000, exp_dist: 32'd300000, exp_n: 2000};

    RST                 = 1'b0;
    radar_pulse_trigger = 1'b0;
    target_enable       = 1'b1;
    load_distance       = 1'b0;
    initial_distance    = '0;
    closing_rate        = '0;
    #12;
    chk("rst_echo", radar_echo, 0);
    chk("rst_dist", target_distance, 0);
    chk("rst_count", echo_count, 0);
    chk("rst_overrun", pulse_overrun, 0);
    chk("rst_busy", busy, 0);
    RST = 1'b1;
    tick();

    // Range table, rate 0 so motion never alters the range.
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].load);
      chk($sformatf("vec%0d_dist", i), target_distance, vecs[i].exp_dist);
      arm();
      run_echo(vecs[i].exp_n, 0, 0, $sformatf("vec%0d", i));
      exp_count = exp_count + 16'd1;
      chk($sformatf("vec%0d_count", i), echo_count, exp_count);
    end
    chk("no_overrun_yet", pulse_overrun, 0);

    // Ceiling-limited build.
    do_load(32'd150000);
    chk("clamp_dflt_dist", target_distance, 150000);
    chk("clamp_low_dist", c_distance, 100000);

    // Second fall during DELAY.
    do_load(32'd3000);
    arm();
    run_echo(20, 5, 0, "overrun_delay");
    exp_count = exp_count + 16'd1;
    chk("overrun_delay_flag", pulse_overrun, 1);
    chk("overrun_delay_count", echo_count, exp_count);

    // Enable dropped mid-DELAY, then a trigger with the target absent.
    arm();
    run_echo(-1, 0, 10, "disable");
    chk("disable_count", echo_count, exp_count);
    target_enable = 1'b0;
    arm();
    run_echo(-1, 0, 0, "miss");
    chk("miss_count", echo_count, exp_count);

    // Approach at 150 m per tick for 10 ticks.
    closing_rate = 32'sd150;
    do_load(32'd6000);
    repeat (10000) tick();
    chk("approach_dist", target_distance, 4500);
    arm();
    run_echo(30, 0, 0, "approach");
    exp_count = exp_count + 16'd1;

    // Receding saturates at the ceiling.
    closing_rate = -32'sd200000;
    repeat (2000) tick();
    chk("recede_sat", target_distance, 300000);

    // Approaching saturates at zero.
    closing_rate = 32'sd10000;
    do_load(32'd25000);
    repeat (2000) tick();
    chk("approach_mid", target_distance, 5000);
    repeat (1000) tick();
    chk("approach_sat", target_distance, 0);

    // Motion tick lands 5 cycles after the fall; delay keeps the snapshot.
    closing_rate = 32'sd1500;
    do_load(32'd3000);
    radar_pulse_trigger = 1'b1;
    repeat (994) tick();
    run_echo(20, 0, 0, "snapshot");
    exp_count = exp_count + 16'd1;
    chk("snapshot_dist", target_distance, 1500);
    chk("snapshot_count", echo_count, exp_count);
    closing_rate = '0;

    // Async reset in the middle of an echo pulse.
    do_load(32'd3000);
    arm();
    radar_pulse_trigger = 1'b0;
    tick();
    repeat (21) tick();
    chk("pre_reset_echo", radar_echo, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_echo", radar_echo, 0);
    chk("async_dist", target_distance, 0);
    chk("async_count", echo_count, 0);
    chk("async_overrun", pulse_overrun, 0);
    chk("async_busy", busy, 0);
    #3;
    RST = 1'b1;
    exp_count = '0;
    tick();

    // Fall on the edge ECHO returns to IDLE: overrun, no second echo.
    do_load(32'd3000);
    arm();
    run_echo(20, 24, 0, "exit_edge");
    exp_count = exp_count + 16'd1;
    chk("exit_edge_overrun", pulse_overrun, 1);
    chk("exit_edge_count", echo_count, exp_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
